imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Registered, parametrised immediate-generation stage for the decode pipeline. Accepts instruction words and an immediate-type select over a valid/ready handshake.
- Produces the XLEN-wide extended immediate one cycle later. A 2-entry skid buffer gives full throughput with registered ready.
- Supports RV32/RV64 widths and the CSR zimm format. Flags illegal selects and supports a synchronous pipeline flush from the hazard unit.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
SHAMT_W, (XLEN==64 ? 6 : 5), shift-amount width extracted for I-type shifts.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  upstream presents instr/immsrc
in_ready  output  1  stage can accept this cycle (registered)
instr  input  32  full instruction word (bits 6:0 ignored)
immsrc  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 I-shift, 110 CSR zimm, 111 reserved
out_valid  output  1  immext/illegal valid
out_ready  input  1  downstream accepts
immext  output  XLEN  extended immediate
illegal  output  1  immsrc was 111 for this entry

Behaviour:
- Reset (reset_n low, async): out_valid=0, immext=0, illegal=0, in_ready=0, skid entry empty. in_ready rises at the first clk edge after reset_n deasserts.
- Formats, computed at input and registered:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - U: sext({instr[31:12], 12'b0}); sign-extended above bit 31 when XLEN=64.
  - I-shift: zext(instr[20+SHAMT_W-1:20]).
  - CSR zimm: zext(instr[19:15]).
  - 111: immext=0, illegal=1. All other selects give illegal=0.
- sext/zext extend to XLEN from the most-significant listed bit.
- Latency: 1 cycle from input handshake (in_valid & in_ready) to out_valid when the output register is empty or draining.
- Output register (OR) plus one skid entry (SK). Each edge:
  - Output fire (out_valid & out_ready): OR takes SK if SK full, else the incoming accepted entry, else becomes empty.
  - Accept while OR is full and not firing: entry goes to SK.
  - in_ready(next) = SK empty after the update.
- Ordering strictly FIFO; no entry dropped or duplicated.
- out_valid held high with immext/illegal stable until out_ready (no retraction, no change while stalled).
- flush=1 at an edge:
  - OR and SK are emptied and out_valid=0 next cycle.
  - An input handshake in the same cycle is discarded.
  - in_ready=1 next cycle.
  - flush overrides out_ready.
- Simultaneous input accept and output fire with SK empty: OR loads the new entry, out_valid stays 1 (back-to-back).
- Reset asserted mid-transfer: all entries lost immediately; no output until new input.
- instr and immsrc are don't-care when in_valid=0. Values outside legal XLEN are unsupported; simulation elaboration check errors.

Test Plan:
- XLEN=32, instr=0xFFF00093, immsrc=000, out_ready=1 -> next cycle out_valid=1, immext=0xFFFFFFFF, illegal=0.
- XLEN=32, instr=0xFE000EE3 (beq -4), immsrc=010 -> immext=0xFFFFFFFC; then immsrc=111 -> immext=0, illegal=1.
- XLEN=64:
  - instr=0x03F09093, immsrc=101 -> immext=0x000000000000003F.
  - instr=0x800000B7, immsrc=100 -> immext=0xFFFFFFFF80000000.
  - instr with [19:15]=11111, immsrc=110 -> immext=0x1F.
- Backpressure: stream 4 entries with out_ready=0 -> two accepted, in_ready=0 from cycle 2. Raise out_ready -> entries emerge in order, one per cycle, values unchanged, no loss.
- Flush with OR and SK full plus in_valid=1 same cycle -> next cycle out_valid=0, in_ready=1; none of the three entries ever appear.
- Assert reset_n=0 asynchronously between edges while out_valid=1 -> out_valid, immext, illegal and in_ready go 0 immediately. After release, in_ready=1 at the first edge.

Source files
------------

// File: rtl/imm_extend_pipe.sv
// Registered immediate-generation stage for the decode pipeline.
// An output register (OR) backed by one skid entry (SK) gives full
// throughput while in_ready stays a registered signal.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_valid/instr/immsrc are looked at only on such edges;
// out_valid, once high, stays high with immext/illegal unchanged until an
// edge with out_ready high (or flush / reset) removes the entry.
module imm_extend_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      immsrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] immext,
    output logic            illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end

    // Opcode bits never influence the immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    logic [XLEN-1:0] nx_imm;
    logic            nx_ill;

    // Output register and skid entry.
    logic            or_valid, sk_valid;
    logic [XLEN-1:0] or_imm, sk_imm;
    logic            or_ill, sk_ill;
    logic            in_ready_r;

    logic accept;
    logic fire;

    assign accept = in_valid & in_ready_r;
    assign fire   = or_valid & out_ready;

    // Decode the immediate for the word currently presented at the input.
    always_comb begin
        nx_imm = '0;
        nx_ill = 1'b0;
        case (immsrc)
            3'b000: nx_imm = XLEN'($signed(instr[31:20]));
            3'b001: nx_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            3'b010: nx_imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                             instr[11:8], 1'b0}));
            3'b011: nx_imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                             instr[30:21], 1'b0}));
            3'b100: nx_imm = XLEN'($signed({instr[31:12], 12'b0}));
            3'b101: nx_imm = XLEN'(instr[20 +: SHAMT_W]);
            3'b110: nx_imm = XLEN'(instr[19:15]);
            default: begin
                nx_imm = '0;
                nx_ill = 1'b1;
            end
        endcase
    end

    // OR/SK occupancy and data, plus the registered ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            or_valid   <= 1'b0;
            or_imm     <= '0;
            or_ill     <= 1'b0;
            sk_valid   <= 1'b0;
            sk_imm     <= '0;
            sk_ill     <= 1'b0;
            in_ready_r <= 1'b0;
        end else if (flush) begin
            // Drop everything held, including a same-cycle input.
            or_valid   <= 1'b0;
            sk_valid   <= 1'b0;
            in_ready_r <= 1'b1;
        end else if (fire || !or_valid) begin
            // OR is free this edge: refill from SK first to keep FIFO order.
            // With SK full in_ready was low, so no accept can coincide.
            if (sk_valid) begin
                or_valid <= 1'b1;
                or_imm   <= sk_imm;
                or_ill   <= sk_ill;
                sk_valid <= 1'b0;
            end else if (accept) begin
                or_valid <= 1'b1;
                or_imm   <= nx_imm;
                or_ill   <= nx_ill;
            end else begin
                or_valid <= 1'b0;
            end
            in_ready_r <= 1'b1;
        end else begin
            // OR stalled: a new entry parks in SK and closes the input.
            if (accept) begin
                sk_valid <= 1'b1;
                sk_imm   <= nx_imm;
                sk_ill   <= nx_ill;
            end
            in_ready_r <= !(sk_valid || accept);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = or_valid;
    assign immext    = or_imm;
    assign illegal   = or_ill;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: one XLEN=32 and one XLEN=64 instance share the
// same stimulus; each has its own expected queue checked by a monitor.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  immsrc = '0;
    logic        out_ready = 1'b1;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] immext32;
    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] immext64;

    int n_vec = 0;
    int n_err = 0;

    // expected entries: {illegal, 64-bit immediate}
    logic [64:0] exp_q32[$];
    logic [64:0] exp_q64[$];
    logic [64:0] cur32, cur64;

    logic        st32 = 1'b0, st64 = 1'b0;
    logic [64:0] hold32, hold64;

    imm_extend_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .immsrc(immsrc),
        .out_valid(out_valid32), .out_ready(out_ready),
        .immext(immext32), .illegal(illegal32)
    );

    imm_extend_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .immsrc(immsrc),
        .out_valid(out_valid64), .out_ready(out_ready),
        .immext(immext64), .illegal(illegal64)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic longint sext(longint x, int n);
        longint m;
        m = (longint'(1) << n) - 1;
        x = x & m;
        if (((x >> (n - 1)) & 1) != 0) return x - (longint'(1) << n);
        return x;
    endfunction

    function automatic logic [64:0] ref_model(logic [31:0] ins, logic [2:0] src, int xlen);
        longint u, v;
        logic   ill;
        u   = longint'({32'h0, ins});
        v   = 0;
        ill = 1'b0;
        case (src)
            3'd0: v = sext(u >> 20, 12);
            3'd1: v = sext(((u >> 25) << 5) | ((u >> 7) & 31), 12);
            3'd2: v = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                           (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
            3'd3: v = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                           (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
            3'd4: v = sext(u & 64'hFFFF_F000, 32);
            3'd5: v = (u >> 20) & ((xlen == 64) ? 63 : 31);
            3'd6: v = (u >> 15) & 31;
            default: begin v = 0; ill = 1'b1; end
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return {ill, 64'(v)};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(string nm, logic [64:0] act, logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // record every accepted input (a flush discards the same-cycle accept)
    always @(negedge clk) begin
        if (reset_n && !flush && in_valid) begin
            if (in_ready32) exp_q32.push_back(cur32);
            if (in_ready64) exp_q64.push_back(cur64);
        end
    end

    // monitor: pop and compare on each output transfer, check hold-while-stalled
    always @(negedge clk) begin
        if (!reset_n) begin
            st32 = 1'b0;
            st64 = 1'b0;
        end else if (flush) begin
            exp_q32.delete();
            exp_q64.delete();
            st32 = 1'b0;
            st64 = 1'b0;
        end else begin
            if (st32) begin
                chk("hold32_valid", 65'(out_valid32), 65'd1);
                chk("hold32_data", {illegal32, 32'h0, immext32}, hold32);
            end
            if (st64) begin
                chk("hold64_valid", 65'(out_valid64), 65'd1);
                chk("hold64_data", {illegal64, immext64}, hold64);
            end
            if (out_valid32 && out_ready) begin
                if (exp_q32.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL out32: got %h, expected no output", {illegal32, immext32});
                end else chk("out32", {illegal32, 32'h0, immext32}, exp_q32.pop_front());
            end
            if (out_valid64 && out_ready) begin
                if (exp_q64.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL out64: got %h, expected no output", {illegal64, immext64});
                end else chk("out64", {illegal64, immext64}, exp_q64.pop_front());
            end
            st32   = out_valid32 && !out_ready;
            st64   = out_valid64 && !out_ready;
            hold32 = {illegal32, 32'h0, immext32};
            hold64 = {illegal64, immext64};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_entry(logic [31:0] ins, logic [2:0] src);
        instr  = ins;
        immsrc = src;
        cur32  = ref_model(ins, src, 32);
        cur64  = ref_model(ins, src, 64);
    endtask

    task automatic set_dir(logic [31:0] ins, logic [2:0] src, logic [64:0] e32, logic [64:0] e64);
        instr  = ins;
        immsrc = src;
        cur32  = e32;
        cur64  = e64;
    endtask

    // present the current entry until it is accepted (called at posedge+1)
    task automatic send_cur(bit rnd_out);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready32) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            if (rnd_out) out_ready = ($urandom_range(0, 1) == 1);
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL in_ready_timeout: got in_ready=0, expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand(bit rnd_out);
        set_entry($urandom, 3'($urandom_range(0, 7)));
        send_cur(rnd_out);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk); #1;
            if (exp_q32.size() == 0 && exp_q64.size() == 0 && !out_valid32 && !out_valid64) break;
        end
        chk("drain_left", 65'(exp_q32.size() + exp_q64.size()), 65'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // reset state
        #12;
        chk("rst32", {61'h0, out_valid32, in_ready32, illegal32, |immext32}, 65'd0);
        chk("rst64", {61'h0, out_valid64, in_ready64, illegal64, |immext64}, 65'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("rdy_before_edge", {63'h0, in_ready32, in_ready64}, 65'd0);
        @(posedge clk); #1;
        chk("rdy_after_edge", {63'h0, in_ready32, in_ready64}, 65'd3);

        // directed formats
        set_dir(32'hFFF0_0093, 3'd0, {1'b0, 64'h0000_0000_FFFF_FFFF}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        send_cur(1'b0);
        set_dir(32'hFE00_0EE3, 3'd2, {1'b0, 64'h0000_0000_FFFF_FFFC}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFC});
        send_cur(1'b0);
        set_dir(32'hFE00_0EE3, 3'd7, {1'b1, 64'h0}, {1'b1, 64'h0});
        send_cur(1'b0);
        set_dir(32'h03F0_9093, 3'd5, {1'b0, 64'h1F}, {1'b0, 64'h3F});
        send_cur(1'b0);
        set_dir(32'h8000_00B7, 3'd4, {1'b0, 64'h0000_0000_8000_0000}, {1'b0, 64'hFFFF_FFFF_8000_0000});
        send_cur(1'b0);
        set_dir(32'h000F_8073, 3'd6, {1'b0, 64'h1F}, {1'b0, 64'h1F});
        send_cur(1'b0);
        drain();

        // backpressure: two accepted, then in_ready low
        out_ready = 1'b0;
        set_entry($urandom, 3'($urandom_range(0, 6)));
        in_valid = 1'b1;
        @(negedge clk); chk("bp_rdy_c0", 65'(in_ready32 & in_ready64), 65'd1);
        @(posedge clk); #1; set_entry($urandom, 3'($urandom_range(0, 6)));
        @(negedge clk); chk("bp_rdy_c1", 65'(in_ready32 & in_ready64), 65'd1);
        @(posedge clk); #1; set_entry($urandom, 3'($urandom_range(0, 6)));
        @(negedge clk); chk("bp_rdy_c2", 65'(in_ready32 | in_ready64), 65'd0);
        chk("bp_valid_c2", 65'(out_valid32 & out_valid64), 65'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_rdy_c3", 65'(in_ready32 | in_ready64), 65'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_cur(1'b0);
        send_rand(1'b0);
        drain();

        // flush with OR and SK full and in_valid high
        out_ready = 1'b0;
        send_rand(1'b0);
        send_rand(1'b0);
        set_entry($urandom, 3'($urandom_range(0, 7)));
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full", {61'h0, out_valid32, out_valid64, in_ready32, in_ready64}, 65'd3);
        @(posedge clk); #1;
        drain();

        // flush discarding a real same-cycle handshake
        out_ready = 1'b0;
        send_rand(1'b0);
        set_entry($urandom, 3'($urandom_range(0, 7)));
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_hs", {61'h0, out_valid32, out_valid64, in_ready32, in_ready64}, 65'd3);
        @(posedge clk); #1;
        drain();

        // asynchronous reset while out_valid is high
        out_ready = 1'b0;
        send_rand(1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset32", {61'h0, out_valid32, in_ready32, illegal32, |immext32}, 65'd0);
        chk("areset64", {61'h0, out_valid64, in_ready64, illegal64, |immext64}, 65'd0);
        exp_q32.delete();
        exp_q64.delete();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("areset_rdy", {63'h0, in_ready32, in_ready64}, 65'd3);
        repeat (3) @(posedge clk);
        #1;

        // randomized traffic with random backpressure and occasional flush
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                set_entry($urandom, 3'($urandom_range(0, 7)));
                in_valid = 1'b1;
                flush    = 1'b1;
                @(posedge clk); #1;
                flush    = 1'b0;
                in_valid = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            send_rand(1'b1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
